// File: rtl/ss_deserializer_if.sv
// Bus bundle between the serial source and the framing receiver.
// master drives the serial line and strobes, slave returns the received words and status.
interface ss_deserializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              ena;
  logic              serial_in;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        frame_cnt;

  modport master (
    output ena,
    output serial_in,
    output bit_en,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy,
    input  frame_cnt
  );

  modport slave (
    input  ena,
    input  serial_in,
    input  bit_en,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy,
    output frame_cnt
  );
endinterface

// File: rtl/ss_deserializer.sv
// Serial-to-parallel framing receiver: start bit, DATA_W data bits LSB first,
// parity bit, stop bit. Delivers words with parity/framing status and counts
// good frames (wrapping 8-bit counter).
module ss_deserializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic               clk,
  input logic               rst_n,
  ss_deserializer_if.slave  bus
);

  localparam int unsigned CntW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic        ParOdd = (PARITY_ODD != 0);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              mismatch_q, mismatch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic bit_ev;
  assign bit_ev = bus.ena & bus.bit_en;

  // State, datapath and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mismatch_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mismatch_q <= mismatch_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: everything holds unless a bit event occurs; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mismatch_d = mismatch_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    if (bit_ev) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.serial_in) begin
            state_d   = StData;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        StData: begin
          // Right shift so the first data bit lands in bit 0.
          shift_d = {bus.serial_in, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == LastBit) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        StParity: begin
          mismatch_d = (^shift_q) ^ bus.serial_in ^ ParOdd;
          state_d    = StStop;
        end
        StStop: begin
          // A low stop bit is a framing error, never a new start bit.
          if (bus.serial_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = mismatch_q;
            if (!mismatch_q) begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            ferr_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_ss_deserializer.sv
// Scoreboard bench for ss_deserializer: stimulus pushes expected frame results,
// a negedge monitor pops and compares whenever a status pulse appears.
module tb_ss_deserializer;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PARITY_ODD = 0;

  logic clk;
  logic rst_n;

  ss_deserializer_if #(.DATA_W(DATA_W)) bus ();

  ss_deserializer #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] model_cnt  = 8'h00;
  int         pulses_exp = 0;
  int         pulses_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a status pulse consumes exactly one expected result.
  always @(negedge clk) begin
    if (rst_n && (bus.data_valid || bus.frame_err || bus.parity_err)) begin
      pulses_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_err", int'(bus.frame_err), int'(e.ferr));
        chk("data_valid", int'(bus.data_valid), int'(!e.ferr));
        chk("parity_err", int'(bus.parity_err), int'(e.perr));
        chk("data_out", int'(bus.data_out), int'(e.data));
        chk("frame_cnt", int'(bus.frame_cnt), int'(e.cnt));
        chk("busy_after_stop", int'(bus.busy), 0);
      end
    end
  end

  // One bit event; bit_en stays high across consecutive calls.
  task automatic send_bit(input logic b);
    bus.serial_in = b;
    bus.bit_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.bit_en    = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold ena low for n cycles while bit_en toggles and the line carries junk.
  task automatic freeze(input int n);
    bus.ena = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.bit_en    = i[0];
      bus.serial_in = i[1];
      @(posedge clk);
      #1;
    end
    bus.bit_en = 1'b0;
    bus.ena    = 1'b1;
  endtask

  // Full frame. flip inverts the correct parity bit; freeze_at inserts an ena-low
  // window before data bit index freeze_at (-1 for none).
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input int gap, input int freeze_at);
    exp_t e;
    logic par;
    par = (^d) ^ (PARITY_ODD != 0) ^ flip;
    if (stop) begin
      model_data = d;
      if (!flip) model_cnt = model_cnt + 8'd1;
      e.ferr = 1'b0;
      e.perr = flip;
    end else begin
      e.ferr = 1'b1;
      e.perr = 1'b0;
    end
    e.data = model_data;
    e.cnt  = model_cnt;
    sb.push_back(e);
    pulses_exp++;
    send_bit(1'b0);
    if (gap > 0) idle_cycles(gap);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == freeze_at) freeze(5);
      send_bit(d[i]);
      if (gap > 0) idle_cycles(gap);
    end
    send_bit(par);
    if (gap > 0) idle_cycles(gap);
    send_bit(stop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_data_valid", int'(bus.data_valid), 0);
    chk("rst_parity_err", int'(bus.parity_err), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_frame_cnt", int'(bus.frame_cnt), 0);
    model_data = 8'h00;
    model_cnt  = 8'h00;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    bus.ena       = 1'b1;
    bus.serial_in = 1'b1;
    bus.bit_en    = 1'b0;
    rst_n         = 1'b1;
    #2;
    do_reset();

    // Good 0xA5, continuous strobes, then idle line.
    send_frame(8'hA5, 1'b0, 1'b1, 0, -1);
    send_bit(1'b1);
    chk("cnt_after_a5", int'(bus.frame_cnt), 1);
    chk("busy_idle_a5", int'(bus.busy), 0);

    // Parity error: delivered but not counted.
    send_frame(8'h3C, 1'b1, 1'b1, 0, -1);
    idle_cycles(2);
    chk("cnt_after_perr", int'(bus.frame_cnt), 1);

    // Framing error keeps previous data, then idle 1 and a good 0x11.
    send_frame(8'h5A, 1'b0, 1'b0, 0, -1);
    idle_cycles(1);
    chk("data_kept_ferr", int'(bus.data_out), 8'h3C);
    chk("busy_after_ferr", int'(bus.busy), 0);
    send_bit(1'b1);
    chk("idle_after_ferr", int'(bus.busy), 0);
    send_frame(8'h11, 1'b0, 1'b1, 0, -1);
    idle_cycles(2);

    // Gapped strobes with an ena-low window mid-frame.
    send_frame(8'hC3, 1'b0, 1'b1, 3, 4);
    idle_cycles(3);
    chk("data_c3", int'(bus.data_out), 8'hC3);
    chk("cnt_c3", int'(bus.frame_cnt), 3);

    // Reset after 4 data bits loses the partial frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    chk("busy_mid_frame", int'(bus.busy), 1);
    do_reset();
    send_frame(8'h7E, 1'b0, 1'b1, 0, -1);
    idle_cycles(2);
    chk("data_7e", int'(bus.data_out), 8'h7E);
    chk("cnt_7e", int'(bus.frame_cnt), 1);

    // 256 back-to-back good frames from a clean counter: wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      v = 8'(i * 37 + 5);
      send_frame(v, 1'b0, 1'b1, 0, -1);
    end
    idle_cycles(3);
    chk("cnt_wrap", int'(bus.frame_cnt), 0);
    chk("busy_end", int'(bus.busy), 0);

    idle_cycles(5);
    chk("sb_empty", sb.size(), 0);
    chk("pulse_count", pulses_seen, pulses_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ss_deserializer.md
# ss_deserializer

Serial-to-parallel framing receiver that sits directly downstream of the serial-in/serial-out register and consumes its serial output bit stream. It detects framed words (start bit, DATA_W data bits LSB first, parity bit, stop bit), reassembles them into parallel words and reports parity and framing errors. It also keeps a wrap-around count of good frames for the top level to expose on its outputs.

## Interface

- DATA_W, 8, number of data bits per frame (legal 4..8)
- PARITY_ODD, 0, 0 = even parity over data bits, 1 = odd parity

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; clears all state and outputs immediately
- ena  input  1  block enable; when low, bit_en is ignored and all state is held
- serial_in  input  1  serial bit from upstream shift register
- bit_en  input  1  bit strobe; serial_in is sampled on a rising edge where bit_en=1 and ena=1 (a "bit event")
- data_out  output  DATA_W  last received word, held until the next accepted frame
- data_valid  output  1  one-cycle pulse: data_out was updated by a completed frame
- parity_err  output  1  one-cycle pulse coincident with data_valid when the parity bit mismatches
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0, frame discarded
- busy  output  1  high whenever the FSM is not in IDLE
- frame_cnt  output  8  count of frames accepted with good parity, wraps 255 -> 0

## Operation

- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on bit events.
- IDLE: serial_in=1 -> stay (idle line). serial_in=0 -> start bit; go to DATA, clear bit counter and shift register.
- DATA: each bit event shifts serial_in into the MSB of a DATA_W shift register (right-shift), so the first data bit ends up in data_out[0]. After the DATA_W-th bit -> PARITY.
- PARITY: sample the parity bit; store mismatch = (^shift ^ serial_in ^ PARITY_ODD) != 0. -> STOP.
- STOP, serial_in=1: load data_out <= shift, pulse data_valid, pulse parity_err = stored mismatch. If no mismatch, frame_cnt <= frame_cnt+1 (mod 256). -> IDLE.
- STOP, serial_in=0: pulse frame_err; data_out, frame_cnt unchanged; no data_valid. -> IDLE. This 0 is not reinterpreted as a start bit.
- Frames with a parity error are still delivered (data_valid=1, parity_err=1) but not counted.
- No oversampling and no glitch filtering: one bit event equals one bit.
- ena=0: FSM, counters and shift register frozen; pulses still deassert on the next edge.

## Timing

- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, frame_cnt=0, FSM=IDLE.
- All outputs registered. data_valid, parity_err and frame_err are high for exactly the one cycle following the edge that sampled the stop bit. They are 0 in every other cycle, even if bit_en stays high continuously.
- Latency: data_out valid one cycle after the stop-bit edge. A minimum frame is DATA_W+3 bit events.
- busy rises the cycle after the start-bit edge. It falls the cycle after the stop-bit edge, together with the pulses.
- Back-to-back frames: a start bit on the bit event immediately after the stop bit is accepted. No idle bit is required.
- Arbitrary gaps (bit_en low) between bit events have no effect on the result.
- rst_n low mid-frame: immediate return to the reset values. A partial frame is lost, and no pulse is produced for it after reset releases.

## Test plan

- Good frame, bit_en every cycle: 0, 1,0,1,0,0,1,0,1, 0, 1 (0xA5, even parity 0) -> data_out=0xA5, data_valid and parity_err=0 for one cycle, frame_cnt=1, busy=0 afterwards.
- Parity error: 0x3C with parity bit 1, stop 1 -> data_out=0x3C, data_valid=1, parity_err=1 (same cycle), frame_cnt unchanged.
- Frame error: 0x5A with correct parity and stop bit 0 -> frame_err pulse only, data_out keeps previous value, FSM IDLE; a following idle 1 then a good 0x11 frame -> data_out=0x11.
- Gapped/gated strobes: 0xC3 sent with 3 idle cycles between bit events, and ena=0 for 5 cycles mid-frame with bit_en toggling -> data_out=0xC3, single data_valid.
- Back-to-back: 256 consecutive good frames with no idle bits -> 256 data_valid pulses, frame_cnt wraps to 0.
- Reset mid-frame: rst_n low after 4 data bits -> all outputs 0 immediately, busy=0; a subsequent full 0x7E frame -> data_out=0x7E, frame_cnt=1.
